// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754-style floating-point adder/subtractor with a fixed latency.
// Specials are resolved in S1 and ride down the pipe. Results are RNE rounded, subnormals flush to zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     sub,
  input  logic                     arg_vld,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [1:0]               state,
  output logic                     res_vld
);
  localparam int W   = EXP_W + MAN_W + 1;
  localparam int M   = MAN_W + 1;          // significand with hidden bit
  localparam int SW  = M + 3;              // significand plus G/R/S
  localparam int XW  = EXP_W + 2;          // two's-complement exponent
  localparam int LZW = $clog2(SW + 1);
  localparam logic [1:0] ST_OK = 2'b00, ST_NAN = 2'b01, ST_INF = 2'b10, ST_NUL = 2'b11;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + LZW'(1);
      end
    end
  endfunction

  // S1: unpack, classify, special results, magnitude swap
  logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             c1_spec;
  logic [W-1:0]     c1_spec_res;
  logic [1:0]       c1_spec_st;

  always_comb begin
    sa     = a[W-1];
    sb     = b[W-1] ^ sub;
    ea     = a[W-2:MAN_W];
    eb     = b[W-2:MAN_W];
    fa     = a[MAN_W-1:0];
    fb     = b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    swap   = {eb, fb} > {ea, fa};
    c1_spec     = 1'b1;
    c1_spec_res = '0;
    c1_spec_st  = ST_OK;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      c1_spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      c1_spec_st  = ST_NAN;
    end else if (a_inf) begin
      c1_spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c1_spec_st  = ST_INF;
    end else if (b_inf) begin
      c1_spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c1_spec_st  = ST_INF;
    end else if (a_zero && b_zero) begin
      c1_spec_res = {sa & sb, {(W-1){1'b0}}};
      c1_spec_st  = ST_NUL;
    end else if (a_zero) begin
      c1_spec_res = {sb, b[W-2:0]};
    end else if (b_zero) begin
      c1_spec_res = a;
    end else begin
      c1_spec = 1'b0;
    end
  end

  logic             s1_vld, s2_vld, s3_vld, s4_vld;
  logic             s1_spec, s2_spec, s3_spec;
  logic [W-1:0]     s1_spec_res, s2_spec_res, s3_spec_res, s4_res;
  logic [1:0]       s1_spec_st, s2_spec_st, s3_spec_st, s4_st;
  logic             s1_sign, s2_sign, s3_sign, s1_eff_sub, s2_eff_sub, s3_zero;
  logic [EXP_W-1:0] s1_exp_big, s1_exp_sml, s2_exp;
  logic [M-1:0]     s1_man_big, s1_man_sml;
  logic [SW-1:0]    s2_big, s2_sml, s3_sig;
  logic [XW-1:0]    s3_exp;

  // S2: align the smaller significand, collapsing shifted-out bits into sticky
  logic [EXP_W-1:0] d;
  logic [SW-1:0]    ext, shifted, lost, aligned;

  always_comb begin
    d       = s1_exp_big - s1_exp_sml;
    ext     = {s1_man_sml, 3'b000};
    shifted = ext >> d;
    lost    = ext & ~({SW{1'b1}} << d);
    if (32'(d) >= MAN_W + 3) aligned = {{(SW-1){1'b0}}, |ext};
    else                     aligned = {shifted[SW-1:1], shifted[0] | (|lost)};
  end

  // S3: add or subtract magnitudes, then normalise
  logic [SW:0]     sum;
  logic [LZW-1:0]  lz;
  logic [SW-1:0]   c3_sig;
  logic [XW-1:0]   c3_exp;

  always_comb begin
    sum = s2_eff_sub ? ({1'b0, s2_big} - {1'b0, s2_sml}) : ({1'b0, s2_big} + {1'b0, s2_sml});
    lz  = lzc(sum[SW-1:0]);
    if (sum[SW]) begin
      c3_sig = {sum[SW:2], sum[1] | sum[0]};
      c3_exp = XW'(s2_exp) + XW'(1);
    end else begin
      c3_sig = sum[SW-1:0] << lz;
      c3_exp = XW'(s2_exp) - XW'(lz);
    end
  end

  // S4: round to nearest even, range check, pick special or computed result
  logic            rnd_up;
  logic [M:0]      man_r;
  logic [MAN_W-1:0] frac;
  logic [XW-1:0]   exp_r;
  logic [W-1:0]    c4_res;
  logic [1:0]      c4_st;

  always_comb begin
    rnd_up = s3_sig[2] & (s3_sig[1] | s3_sig[0] | s3_sig[3]);
    man_r  = {1'b0, s3_sig[SW-1:3]} + (M+1)'(rnd_up);
    frac   = man_r[M] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    exp_r  = s3_exp + XW'(man_r[M]);
    c4_res = {s3_sign, exp_r[EXP_W-1:0], frac};
    c4_st  = ST_OK;
    if (s3_spec) begin
      c4_res = s3_spec_res;
      c4_st  = s3_spec_st;
    end else if (s3_zero) begin
      c4_res = '0;
      c4_st  = ST_NUL;
    end else if (!exp_r[XW-1] && (exp_r[XW-2:0] >= (XW-1)'((1 << EXP_W) - 1))) begin
      c4_res = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c4_st  = ST_INF;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      c4_res = {s3_sign, {(W-1){1'b0}}};
      c4_st  = ST_NUL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      s4_vld  <= 1'b0;
      res_vld <= 1'b0;
      result  <= '0;
      state   <= ST_OK;
    end else begin
      s1_vld  <= arg_vld;
      s2_vld  <= s1_vld;
      s3_vld  <= s2_vld;
      s4_vld  <= s3_vld;
      res_vld <= s4_vld;
      if (s4_vld) begin
        result <= s4_res;
        state  <= s4_st;
      end
    end
  end

  // Zero operands always take the special path, so the hidden bit is prepended unconditionally.
  always_ff @(posedge clk) begin
    s1_spec     <= c1_spec;
    s1_spec_res <= c1_spec_res;
    s1_spec_st  <= c1_spec_st;
    s1_sign     <= swap ? sb : sa;
    s1_eff_sub  <= sa ^ sb;
    s1_exp_big  <= swap ? eb : ea;
    s1_exp_sml  <= swap ? ea : eb;
    s1_man_big  <= swap ? {1'b1, fb} : {1'b1, fa};
    s1_man_sml  <= swap ? {1'b1, fa} : {1'b1, fb};
    s2_spec     <= s1_spec;
    s2_spec_res <= s1_spec_res;
    s2_spec_st  <= s1_spec_st;
    s2_sign     <= s1_sign;
    s2_eff_sub  <= s1_eff_sub;
    s2_exp      <= s1_exp_big;
    s2_big      <= {s1_man_big, 3'b000};
    s2_sml      <= aligned;
    s3_spec     <= s2_spec;
    s3_spec_res <= s2_spec_res;
    s3_spec_st  <= s2_spec_st;
    s3_sign     <= s2_sign;
    s3_zero     <= (sum == '0);
    s3_exp      <= c3_exp;
    s3_sig      <= c3_sig;
    s4_res      <= c4_res;
    s4_st       <= c4_st;
  end
endmodule
